// File: rtl/ysyx_24100005_pkg.sv
// Shared constants for the ysyx_24100005 core.
//   REG_ADDR_W : default register index width
//   XLEN       : default integer register width
//   NUM_REGS   : architectural register count
//   ZERO_REG   : index of the hard-wired zero register
package ysyx_24100005_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/ysyx_24100005_Reg.sv
// Single register with write enable and async active-low clear.
//   clk  : clock, captures d on rising edge when en=1
//   rst  : async reset, active low, clears q to 0
//   en   : write enable
//   d    : write data
//   q    : stored value
module ysyx_24100005_Reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/ysyx_24100005_register_file.sv
// Integer register file: two combinational read ports, one synchronous
// write port, x0 hard-wired to zero, async active-low clear of all entries.
//   clk             : clock, writes on rising edge
//   rst             : async reset, active low
//   wen/waddr/wdata : write port
//   rs1addr/rs1data : read port 1 (combinational)
//   rs2addr/rs2data : read port 2 (combinational)
module ysyx_24100005_register_file
    import ysyx_24100005_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] rs1addr,
    input  logic [ADDR_WIDTH-1:0] rs2addr,
    output logic [DATA_WIDTH-1:0] rs1data,
    output logic [DATA_WIDTH-1:0] rs2data
);

    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs [NREGS];

    // Entry 0 has no storage; tie it off so the read mux is uniform.
    assign regs[0] = '0;

    generate
        for (genvar i = 1; i < NREGS; i++) begin : g_reg
            ysyx_24100005_Reg #(
                .WIDTH (DATA_WIDTH)
            ) u_reg (
                .clk (clk),
                .rst (rst),
                .en  (wen && (waddr == ADDR_WIDTH'(i))),
                .d   (wdata),
                .q   (regs[i])
            );
        end
    endgenerate

    // No write bypass: a same-cycle write shows up only after the edge.
    assign rs1data = (rs1addr == ZERO_IDX) ? '0 : regs[rs1addr];
    assign rs2data = (rs2addr == ZERO_IDX) ? '0 : regs[rs2addr];

endmodule

// File: tb/tb_ysyx_24100005_register_file.sv
module tb_ysyx_24100005_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rs1addr;
    logic [4:0]  rs2addr;
    logic [31:0] rs1data;
    logic [31:0] rs2data;

    int errors = 0;
    int checks = 0;

    ysyx_24100005_register_file #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .rs1addr (rs1addr),
        .rs2addr (rs2addr),
        .rs1data (rs1data),
        .rs2data (rs2data)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        string       name;
        bit          port;
        logic [31:0] val;
    } exp_t;

    vec_t vt[10];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input bit port, input logic [31:0] val);
        exp_t e;
        e.name = nm;
        e.port = port;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries want >=1");
        end else begin
            e = sb.pop_front();
            chk(e.name, e.port ? rs2data : rs1data, e.val);
        end
    endtask

    initial begin
        rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; rs1addr = '0; rs2addr = '0;

        // Vectors: write at the edge, read back right after it.
        vt[0] = '{1'b1, 5'd1,  32'h12345678, 5'd1,  5'd31, 32'h12345678, 32'h0};
        vt[1] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd1,  5'd31, 32'h12345678, 32'hFFFFFFFF};
        vt[2] = '{1'b1, 5'd0,  32'hA5A5A5A5, 5'd0,  5'd0,  32'h0,        32'h0};
        vt[3] = '{1'b1, 5'd7,  32'h00000011, 5'd7,  5'd1,  32'h00000011, 32'h12345678};
        vt[4] = '{1'b0, 5'd7,  32'h00000022, 5'd7,  5'd7,  32'h00000011, 32'h00000011};
        vt[5] = '{1'b1, 5'd3,  32'h00000001, 5'd3,  5'd31, 32'h00000001, 32'hFFFFFFFF};
        vt[6] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd3,  32'hDEADBEEF, 32'h00000001};
        vt[7] = '{1'b1, 5'd31, 32'h00000000, 5'd31, 5'd30, 32'h0,        32'h0};
        vt[8] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
        vt[9] = '{1'b1, 5'd31, 32'h0BADF00D, 5'd31, 5'd5,  32'h0BADF00D, 32'hDEADBEEF};

        // Reset state.
        #5;
        for (int a = 0; a < 32; a += 8) begin
            rs1addr = 5'(a); rs2addr = 5'(31 - a);
            #1;
            chk("reset_rs1", rs1data, 32'h0);
            chk("reset_rs2", rs2data, 32'h0);
        end

        // Release mid-cycle, away from any edge.
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wen = vt[i].wen; waddr = vt[i].waddr; wdata = vt[i].wdata;
            rs1addr = vt[i].a1; rs2addr = vt[i].a2;
            push($sformatf("vec%0d_rs1", i), 1'b0, vt[i].e1);
            push($sformatf("vec%0d_rs2", i), 1'b1, vt[i].e2);
            @(posedge clk);
            #1;
            wen = 1'b0;
            pop_chk();
            pop_chk();
        end

        // Same-cycle read/write of x3: old value before the edge, new after.
        @(negedge clk);
        rs1addr = 5'd3; rs2addr = 5'd3;
        wen = 1'b1; waddr = 5'd3; wdata = 32'h2;
        #1;
        chk("rw_before_rs1", rs1data, 32'h1);
        chk("rw_before_rs2", rs2data, 32'h1);
        @(posedge clk);
        #1;
        wen = 1'b0;
        chk("rw_after_rs1", rs1data, 32'h2);
        chk("rw_after_rs2", rs2data, 32'h2);

        // Mid-cycle reset clears everything at once, no edge needed.
        @(negedge clk);
        rs1addr = 5'd5;
        #1;
        chk("pre_reset_x5", rs1data, 32'hDEADBEEF);
        #2;
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1addr = 5'(a); rs2addr = 5'(31 - a);
            #1;
            chk($sformatf("midreset_rs1_x%0d", a), rs1data, 32'h0);
            chk($sformatf("midreset_rs2_x%0d", 31 - a), rs2data, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Reset racing a pending write to x4.
        @(negedge clk);
        wen = 1'b1; waddr = 5'd4; wdata = 32'h55; rs1addr = 5'd4; rs2addr = 5'd4;
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("race_x4_held", rs1data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("race_x4_after_release", rs2data, 32'h0);
        @(posedge clk);
        #1;
        wen = 1'b0;
        chk("race_x4_written", rs1data, 32'h55);
        chk("race_x4_rs2", rs2data, 32'h55);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
